// File: rtl/scanline_fetch_controller.sv
// Scanline fetch controller: copies one line of VRAM words into a ping-pong
// line buffer ahead of each visible line and gives the host every HOST_SLOT-th cycle.
module scanline_fetch_controller #(
    parameter int COUNT_WIDTH      = 10,
    parameter int ADDR_WIDTH       = 16,
    parameter int FETCH_LEN        = 320,
    parameter int H_TRIGGER        = 640,
    parameter int V_VISIBLE_START  = 35,
    parameter int V_VISIBLE_LENGTH = 480,
    parameter int V_TOTAL          = 525,
    parameter int HOST_SLOT        = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [COUNT_WIDTH-1:0] h_pos,
    input  logic [COUNT_WIDTH-1:0] v_pos,
    input  logic                   enable,
    input  logic [ADDR_WIDTH-1:0]  base_addr,
    input  logic [ADDR_WIDTH-1:0]  line_stride,
    input  logic                   host_req,
    input  logic [ADDR_WIDTH-1:0]  host_addr,
    input  logic                   clear_underrun,
    output logic                   host_grant,
    output logic [ADDR_WIDTH-1:0]  vram_addr,
    output logic                   vram_rd,
    output logic                   lbuf_wr,
    output logic [8:0]             lbuf_addr,
    output logic                   lbuf_bank,
    output logic                   busy,
    output logic                   underrun
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_FETCH = 1'b1;

    localparam int WC_W   = $clog2(FETCH_LEN + 1);
    localparam int SLOT_W = (HOST_SLOT > 1) ? $clog2(HOST_SLOT) : 1;

    localparam logic [COUNT_WIDTH-1:0] V_LAST  = COUNT_WIDTH'(V_TOTAL - 1);
    localparam logic [COUNT_WIDTH-1:0] V_FIRST = COUNT_WIDTH'(V_VISIBLE_START);
    localparam logic [COUNT_WIDTH-1:0] V_END   = COUNT_WIDTH'(V_VISIBLE_START + V_VISIBLE_LENGTH);
    localparam logic [COUNT_WIDTH-1:0] H_TRIG  = COUNT_WIDTH'(H_TRIGGER);
    localparam logic [WC_W-1:0]        WC_LAST   = WC_W'(FETCH_LEN - 1);
    localparam logic [SLOT_W-1:0]      SLOT_LAST = SLOT_W'(HOST_SLOT - 1);

    logic [0:0]             state, state_nx;
    logic [ADDR_WIDTH-1:0]  line_addr, line_addr_nx;
    logic [WC_W-1:0]        wc, wc_nx;
    logic [SLOT_W-1:0]      slot, slot_nx;
    logic                   bank, bank_nx;
    logic [COUNT_WIDTH-1:0] next_v;
    logic                   next_visible;
    logic                   trigger;
    logic                   fetch_done;
    logic                   host_nx;
    logic                   rd_nx;

    // Registers describe the cycle about to start: wc is the word read during
    // the current cycle when vram_rd is high, slot is the current FETCH cycle index.
    always_comb begin
        next_v       = (v_pos == V_LAST) ? '0 : v_pos + 1'b1;
        next_visible = (next_v >= V_FIRST) && (next_v < V_END);
        trigger      = enable && (h_pos == H_TRIG) && next_visible;
        fetch_done   = vram_rd && (wc == WC_LAST);

        state_nx     = state;
        line_addr_nx = line_addr;
        wc_nx        = wc;
        slot_nx      = slot;
        bank_nx      = bank;

        if (trigger) begin
            state_nx     = S_FETCH;
            line_addr_nx = (next_v == V_FIRST) ? base_addr : line_addr + line_stride;
            wc_nx        = '0;
            slot_nx      = '0;
            bank_nx      = ~bank;
        end else if (state == S_FETCH) begin
            if (fetch_done) begin
                state_nx = S_IDLE;
                wc_nx    = '0;
                slot_nx  = '0;
            end else begin
                wc_nx   = wc + WC_W'(vram_rd);
                slot_nx = (slot == SLOT_LAST) ? '0 : slot + 1'b1;
            end
        end

        if (state_nx == S_FETCH) begin
            host_nx = (slot_nx == SLOT_LAST) && host_req;
        end else begin
            host_nx = host_req;
        end
        rd_nx = (state_nx == S_FETCH) && !host_nx;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            line_addr  <= '0;
            wc         <= '0;
            slot       <= '0;
            bank       <= 1'b0;
            host_grant <= 1'b0;
            vram_addr  <= '0;
            vram_rd    <= 1'b0;
            lbuf_wr    <= 1'b0;
            lbuf_addr  <= '0;
            lbuf_bank  <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            state      <= state_nx;
            line_addr  <= line_addr_nx;
            wc         <= wc_nx;
            slot       <= slot_nx;
            bank       <= bank_nx;
            host_grant <= host_nx;
            vram_rd    <= rd_nx;
            vram_addr  <= rd_nx ? line_addr_nx + ADDR_WIDTH'(wc_nx) : host_addr;
            lbuf_wr    <= vram_rd;
            if (vram_rd) begin
                lbuf_addr <= 9'(wc);
            end
            // Bank follows one cycle late so an in-flight write lands in the old bank.
            lbuf_bank  <= bank;
            if (trigger && (state == S_FETCH)) begin
                underrun <= 1'b1;
            end else if (clear_underrun) begin
                underrun <= 1'b0;
            end
        end
    end

    assign busy = (state == S_FETCH);

endmodule

// File: tb/tb_scanline_fetch_controller.sv
// Randomized bench for scanline_fetch_controller: a line-level reference model
// queues expected reads, writes, grants and status; a negedge monitor checks them.
module tb_scanline_fetch_controller;

    localparam int CW = 10;
    localparam int AW = 16;
    localparam int FL = 320;
    localparam int HT = 640;
    localparam int VS = 35;
    localparam int VL = 480;
    localparam int VT = 525;
    localparam int HS = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [CW-1:0] h_pos = '0;
    logic [CW-1:0] v_pos = '0;
    logic          enable = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW-1:0] line_stride = '0;
    logic          host_req = 1'b0;
    logic [AW-1:0] host_addr = '0;
    logic          clear_underrun = 1'b0;
    logic          host_grant;
    logic [AW-1:0] vram_addr;
    logic          vram_rd;
    logic          lbuf_wr;
    logic [8:0]    lbuf_addr;
    logic          lbuf_bank;
    logic          busy;
    logic          underrun;

    scanline_fetch_controller #(
        .COUNT_WIDTH(CW), .ADDR_WIDTH(AW), .FETCH_LEN(FL), .H_TRIGGER(HT),
        .V_VISIBLE_START(VS), .V_VISIBLE_LENGTH(VL), .V_TOTAL(VT), .HOST_SLOT(HS)
    ) dut (
        .clk(clk), .reset(reset), .h_pos(h_pos), .v_pos(v_pos), .enable(enable),
        .base_addr(base_addr), .line_stride(line_stride), .host_req(host_req),
        .host_addr(host_addr), .clear_underrun(clear_underrun),
        .host_grant(host_grant), .vram_addr(vram_addr), .vram_rd(vram_rd),
        .lbuf_wr(lbuf_wr), .lbuf_addr(lbuf_addr), .lbuf_bank(lbuf_bank),
        .busy(busy), .underrun(underrun)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passed = 0;
    int busy_run = 0;

    // Expected queues, each entry tagged with the cycle it must appear in
    logic [47:0] rd_q[$];   // {cycle, vram_addr}
    logic [41:0] wr_q[$];   // {cycle, bank, index}
    logic [47:0] gr_q[$];   // {cycle, host_addr}
    logic [33:0] st_q[$];   // {cycle, busy, underrun}

    // Reference model: a line is a list of word indices still to fetch
    int m_line = 0;
    bit m_bank = 1'b0;
    bit m_under = 1'b0;
    bit m_cur_fetch = 1'b0;
    int m_idx = 0;
    int m_rem[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: actual %0h required %0h at cycle %0d", name, act, exp, cyc);
    endtask

    task automatic model_step();
        int nv;
        bit trig;
        bit fetching;
        int w;
        nv = (int'(v_pos) == VT - 1) ? 0 : int'(v_pos) + 1;
        trig = enable && (int'(h_pos) == HT) && (nv >= VS) && (nv < VS + VL);
        if (trig && m_cur_fetch) m_under = 1'b1;
        else if (clear_underrun) m_under = 1'b0;
        if (trig) begin
            m_line = (nv == VS) ? int'(base_addr) : (m_line + int'(line_stride)) % 65536;
            m_rem.delete();
            for (int i = 0; i < FL; i++) m_rem.push_back(i);
            m_idx = 0;
            m_bank = !m_bank;
        end
        fetching = m_rem.size() > 0;
        if (fetching) begin
            if ((m_idx % HS == HS - 1) && host_req) begin
                gr_q.push_back({32'(cyc + 1), host_addr});
            end else begin
                w = m_rem.pop_front();
                rd_q.push_back({32'(cyc + 1), 16'(m_line + w)});
                wr_q.push_back({32'(cyc + 2), m_bank, 9'(w)});
            end
            m_idx++;
        end else if (host_req) begin
            gr_q.push_back({32'(cyc + 1), host_addr});
        end
        m_cur_fetch = fetching;
        st_q.push_back({32'(cyc + 1), fetching, m_under});
    endtask

    // Driver tasks
    task automatic step(input int h, input int v, input int hmode, input bit clr);
        @(posedge clk);
        #1;
        h_pos = CW'(h);
        v_pos = CW'(v);
        clear_underrun = clr;
        case (hmode)
            0: host_req = 1'b0;
            1: host_req = 1'b1;
            default: host_req = 1'($urandom_range(0, 1));
        endcase
        host_addr = AW'($urandom_range(0, 65535));
        model_step();
    endtask

    task automatic idle(input int n, input int hmode);
        repeat (n) step($urandom_range(0, HT - 1), $urandom_range(0, VT - 1), hmode, 1'b0);
    endtask

    task automatic trig(input int v, input int hmode, input bit clr);
        step(HT, v, hmode, clr);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("reset_outputs",
              64'({host_grant, vram_addr, vram_rd, lbuf_wr, lbuf_addr, lbuf_bank, busy, underrun}),
              64'(0));
        rd_q.delete(); wr_q.delete(); gr_q.delete(); st_q.delete(); m_rem.delete();
        m_line = 0; m_bank = 1'b0; m_under = 1'b0; m_cur_fetch = 1'b0; m_idx = 0;
        repeat (3) @(posedge clk);
        #1;
        h_pos = '0; host_req = 1'b0; clear_underrun = 1'b0;
        reset = 1'b0;
        model_step();
    endtask

    // Monitor / scoreboard
    logic [63:0] mon_e;
    bit rd_due, wr_due, gr_due;
    always @(negedge clk) begin
        if (!reset) begin
            if (busy) busy_run++;
            rd_due = rd_q.size() > 0 && rd_q[0][47:16] == 32'(cyc);
            if (rd_due) begin
                mon_e = 64'(rd_q.pop_front());
                check("vram_read", 64'({vram_rd, 32'(cyc), vram_addr}), 64'({1'b1, mon_e[47:0]}));
            end else if (vram_rd) begin
                check("vram_read_unexpected", 64'(vram_rd), 64'(0));
            end
            wr_due = wr_q.size() > 0 && wr_q[0][41:10] == 32'(cyc);
            if (wr_due) begin
                mon_e = 64'(wr_q.pop_front());
                check("lbuf_write", 64'({lbuf_wr, 32'(cyc), lbuf_bank, lbuf_addr}), 64'({1'b1, mon_e[41:0]}));
            end else if (lbuf_wr) begin
                check("lbuf_write_unexpected", 64'(lbuf_wr), 64'(0));
            end
            gr_due = gr_q.size() > 0 && gr_q[0][47:16] == 32'(cyc);
            if (gr_due) begin
                mon_e = 64'(gr_q.pop_front());
                check("host_grant", 64'({host_grant, 32'(cyc), vram_addr}), 64'({1'b1, mon_e[47:0]}));
            end else if (host_grant) begin
                check("host_grant_unexpected", 64'(host_grant), 64'(0));
            end
            if (vram_rd || host_grant) check("grant_read_exclusive", 64'(vram_rd & host_grant), 64'(0));
            if (st_q.size() > 0 && st_q[0][33:2] == 32'(cyc)) begin
                mon_e = 64'(st_q.pop_front());
                check("busy_underrun", 64'({busy, underrun}), 64'(mon_e[1:0]));
            end
        end
    end

    initial begin
        #1;
        do_reset();
        enable = 1'b1;
        base_addr = 16'h1000;
        line_stride = 16'd320;

        // First visible line loads base, second adds stride, 514 and 524 do not trigger
        trig(34, 0, 1'b0);
        idle(330, 0);
        trig(35, 0, 1'b0);
        idle(330, 0);
        trig(514, 0, 1'b0);
        idle(5, 0);

        // Host held during a whole fetch
        busy_run = 0;
        trig(36, 1, 1'b0);
        idle(370, 1);
        check("fetch_with_host_cycles", 64'(busy_run), 64'(365));

        // Underrun: retrigger mid-fetch, clear, then set and clear together
        line_stride = AW'($urandom_range(0, 65535));
        trig(37, 0, 1'b0);
        idle(100, 2);
        trig(38, 0, 1'b0);
        idle(10, 2);
        step(0, 100, 2, 1'b1);
        idle(20, 2);
        trig(39, 0, 1'b1);
        idle(340, 2);
        step(0, 100, 0, 1'b1);
        idle(3, 0);

        // Random host traffic during a fetch
        trig(40, 2, 1'b0);
        idle(370, 2);

        // Reset mid-fetch, then restart from word 0 with the first bank
        trig(41, 0, 1'b0);
        idle(100, 0);
        do_reset();
        trig(42, 0, 1'b0);
        idle(330, 2);

        // Frame wrap then reload of a new base
        trig(524, 0, 1'b0);
        idle(5, 0);
        base_addr = AW'($urandom_range(0, 65535));
        trig(34, 0, 1'b0);
        idle(330, 0);

        // Dropping enable keeps the active fetch but blocks the next trigger
        trig(44, 0, 1'b0);
        idle(50, 2);
        enable = 1'b0;
        trig(45, 0, 1'b0);
        idle(300, 2);
        enable = 1'b1;
        idle(5, 0);

        check("reads_outstanding", 64'(rd_q.size()), 64'(0));
        check("writes_outstanding", 64'(wr_q.size()), 64'(0));
        check("grants_outstanding", 64'(gr_q.size()), 64'(0));
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
